alu_cmd_sequencer: RTL
======================

Name: alu_cmd_sequencer

Overview:
Sequences the 32-bit ALU datapath from 12-bit commands. Owns an 8x32 operand register file. Accepts one command per valid/ready handshake, drives registered operands and op code into the combinational ALU, and writes the ALU result back into the register file. Captures the O/C/Z/N flags and reports completion. It sits between the host/run logic and the alu instance, and replaces the ad-hoc operand registers in the top level.

Parameters:
DATA_W, 32, operand/result width
NREGS, 8, register file depth (address width 3, fixed by command format)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd  input  12  command: [11:9] op, [8:6] rd, [5:3] ra, [2:0] rb
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
wr_en  input  1  host register write strobe
wr_addr  input  3  host write address
wr_data  input  32  host write data
wr_err  output  1  one-cycle pulse: host write rejected
rd_addr  input  3  host read address
rd_data  output  32  combinational read of register rd_addr
alu_op  output  3  op code to ALU, registered
alu_a  output  32  operand A to ALU, registered
alu_b  output  32  operand B to ALU, registered
alu_y  input  32  ALU result, combinational from alu_a/alu_b/alu_op
alu_flags  input  4  {O,C,Z,N} from ALU
flags  output  4  last captured {O,C,Z,N}
done  output  1  one-cycle pulse: command written back

Behaviour:
- Reset (async, rst_n=0): state IDLE; cmd_ready=1; done=0; wr_err=0; alu_op/alu_a/alu_b=0; flags=0; all registers=0. Reset mid-command abandons the command; no writeback occurs.
- FSM states: IDLE, READ, EXEC, WB.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch cmd fields and go to READ. The accept cycle is T0.
- READ (T1): cmd_ready=0. alu_a<=reg[ra], alu_b<=reg[rb], alu_op<=op, all registered at the end of T1. Go to EXEC.
- EXEC (T2): alu_y/alu_flags settle. At the end of T2, reg[rd]<=alu_y and flags<=alu_flags. Go to WB.
- WB (T3): done=1 for exactly this cycle. cmd_ready=1, so a new command can be accepted in T3 and the next READ is T4. Go to IDLE, or to READ if a command was accepted.
- Throughput: one command per 3 cycles. Latency: accept to done is 3 cycles.
- Operands read in READ see the writeback of the previous command, because writeback completes before the next READ. No forwarding is needed.
- r0 always reads 0. Writes to r0 (writeback or host) are discarded, but flags are still updated on writeback.
- All 8 op values are passed to the ALU unmodified. The sequencer does not interpret op.
- Host write port:
  - Honoured only in IDLE, or in WB with no new command accepted that cycle.
  - Otherwise the write is dropped and wr_err pulses the next cycle.
  - Host write and writeback can never coincide.
- rd_data: combinational. A write in cycle N is visible from cycle N+1.
- alu_a/alu_b/alu_op hold their values outside READ. They are not cleared.
- cmd_valid while cmd_ready=0 is ignored. The host must hold cmd_valid until the handshake.

Decomposition:
- alu_pkg holds: state enum (IDLE, READ, EXEC, WB); command field positions (OP_MSB=11, RD_LSB=6, RA_LSB=3, RB_LSB=0); DATA_W; flag bit indices (O=3, C=2, Z=1, N=0).
- Sub-module alu_regfile: 8x32, one write port (muxed between writeback and host), three combinational read ports (ra, rb, rd_addr), async clear, r0 hard zero.

Test Plan:
Bench ALU model: op 000 = a+b, op 001 = a-b; flags computed by the model.

1. Reset: assert rst_n=0 mid-EXEC of a pending add -> next cycle cmd_ready=1, flags=0, all rd_data=0, no done pulse.
2. Basic add: host writes r1=5, r2=7; cmd op=000, rd=3, ra=1, rb=2 accepted at T0 -> alu_a=5 and alu_b=7 from T2; done at T3; rd_data(r3)=12; flags=0000.
3. Overflow/zero: r1=0xFFFFFFFF, r2=1, add into r4 -> r4=0, flags C=1 and Z=1 (0110). Then sub of r1-r1 into r5 -> r5=0, Z=1.
4. Back-to-back dependency: command in T3 reads r3 written by the previous command -> uses the new value. Accept-to-accept spacing is exactly 3 cycles.
5. r0 rules: add into rd=0 -> r0 still reads 0, flags updated. Host write r0=9 -> r0 still reads 0.
6. Host write while busy: wr_en in READ -> register unchanged, wr_err pulses once, command completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command sequencer: FSM states,
// command field positions, datapath widths and flag bit indices.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int NREGS  = 8;
  localparam int ADDR_W = 3;
  localparam int OP_W   = 3;
  localparam int CMD_W  = 12;
  localparam int FLAG_W = 4;

  localparam int OP_MSB = 11;
  localparam int RD_LSB = 6;
  localparam int RA_LSB = 3;
  localparam int RB_LSB = 0;

  localparam int FLAG_O = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu_regfile.sv
// Operand register file: one write port, three combinational read ports,
// async clear, register 0 hard-wired to zero.
module alu_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic [ADDR_W-1:0] raddr_h_i,
  output logic [DATA_W-1:0] rdata_h_o
);

  logic [DATA_W-1:0] regs_q [NREGS];

  // Writes to r0 are dropped so it keeps its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];
  assign rdata_h_o = (raddr_h_i == '0) ? '0 : regs_q[raddr_h_i];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Sequences the ALU datapath from 12-bit commands: operand read, execute,
// writeback into the register file, with a host write/read side port.
module alu_cmd_sequencer #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [alu_pkg::CMD_W-1:0]   cmd,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        wr_en,
  input  logic [alu_pkg::ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        wr_err,
  input  logic [alu_pkg::ADDR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0]           rd_data,
  output logic [alu_pkg::OP_W-1:0]    alu_op,
  output logic [DATA_W-1:0]           alu_a,
  output logic [DATA_W-1:0]           alu_b,
  input  logic [DATA_W-1:0]           alu_y,
  input  logic [alu_pkg::FLAG_W-1:0]  alu_flags,
  output logic [alu_pkg::FLAG_W-1:0]  flags,
  output logic                        done
);

  import alu_pkg::*;

  seq_state_e        state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic [ADDR_W-1:0] rb_q, rb_d;
  logic [OP_W-1:0]   alu_op_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [FLAG_W-1:0] flags_q;
  logic              wr_err_q;

  logic              accept;
  logic              host_ok;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata_a, rf_rdata_b;

  assign cmd_ready = (state_q == IDLE) || (state_q == WB);
  assign accept    = cmd_valid && cmd_ready;
  assign done      = (state_q == WB);

  // Host writes only in quiet slots; EXEC owns the write port otherwise.
  assign host_ok   = wr_en && ((state_q == IDLE) || ((state_q == WB) && !accept));
  assign rf_we     = (state_q == EXEC) || host_ok;
  assign rf_waddr  = (state_q == EXEC) ? rd_q  : wr_addr;
  assign rf_wdata  = (state_q == EXEC) ? alu_y : wr_data;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = accept ? READ : IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      op_d = cmd[OP_MSB -: OP_W];
      rd_d = cmd[RD_LSB +: ADDR_W];
      ra_d = cmd[RA_LSB +: ADDR_W];
      rb_d = cmd[RB_LSB +: ADDR_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      flags_q  <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      wr_err_q <= wr_en && !host_ok;
      if (state_q == READ) begin
        alu_op_q <= op_q;
        alu_a_q  <= rf_rdata_a;
        alu_b_q  <= rf_rdata_b;
      end
      if (state_q == EXEC) begin
        flags_q <= alu_flags;
      end
    end
  end

  assign alu_op = alu_op_q;
  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign flags  = flags_q;
  assign wr_err = wr_err_q;

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (ra_q),
    .rdata_a_o (rf_rdata_a),
    .raddr_b_i (rb_q),
    .rdata_b_o (rf_rdata_b),
    .raddr_h_i (rd_addr),
    .rdata_h_o (rd_data)
  );

endmodule
